// File: rtl/mpt_mem_arbiter.sv
// rtl/mpt_mem_arbiter.sv - two-walker MEM-port arbiter with request locking and in-order response routing
//
// Purpose:
//   Shares one MEM master port between the load-unit walker (slave 0) and
//   the store-unit walker (slave 1). Arbitration is round-robin. Once a
//   request is presented downstream but not accepted, the grant is locked to
//   that walker until its handshake completes. An in-order ID FIFO steers each
//   response back to the walker that issued the matching request. Neither the
//   request path nor the response path adds a cycle of latency.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   s{0,1}_mem_req/gnt        walker request handshake
//   s{0,1}_mem_addr/wdata/we/be  walker request fields
//   s{0,1}_mem_valid/rdata/error walker response
//   m_mem_req/gnt             downstream request handshake
//   m_mem_addr/wdata/we/be    forwarded request fields
//   m_mem_valid/rdata/error   downstream response
//   busy_o                    a request is pending or responses are outstanding
//   protocol_err_o            sticky: a response arrived with no outstanding ID

module mpt_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    s0_mem_req,
  output logic                    s0_mem_gnt,
  input  logic [ADDR_WIDTH-1:0]   s0_mem_addr,
  input  logic [DATA_WIDTH-1:0]   s0_mem_wdata,
  input  logic                    s0_mem_we,
  input  logic [DATA_WIDTH/8-1:0] s0_mem_be,
  output logic                    s0_mem_valid,
  output logic [DATA_WIDTH-1:0]   s0_mem_rdata,
  output logic                    s0_mem_error,

  input  logic                    s1_mem_req,
  output logic                    s1_mem_gnt,
  input  logic [ADDR_WIDTH-1:0]   s1_mem_addr,
  input  logic [DATA_WIDTH-1:0]   s1_mem_wdata,
  input  logic                    s1_mem_we,
  input  logic [DATA_WIDTH/8-1:0] s1_mem_be,
  output logic                    s1_mem_valid,
  output logic [DATA_WIDTH-1:0]   s1_mem_rdata,
  output logic                    s1_mem_error,

  output logic                    m_mem_req,
  input  logic                    m_mem_gnt,
  output logic [ADDR_WIDTH-1:0]   m_mem_addr,
  output logic [DATA_WIDTH-1:0]   m_mem_wdata,
  output logic                    m_mem_we,
  output logic [DATA_WIDTH/8-1:0] m_mem_be,
  input  logic                    m_mem_valid,
  input  logic [DATA_WIDTH-1:0]   m_mem_rdata,
  input  logic                    m_mem_error,

  output logic                    busy_o,
  output logic                    protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                       rr_q;
  logic                       lock_q;
  logic                       lock_id_q;
  logic [CNT_W-1:0]           count_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [MAX_OUTSTANDING-1:0] id_fifo_q;
  logic                       protocol_err_q;

  logic sel;
  logic sel_req;
  logic fifo_full;
  logic fifo_nonempty;
  logic handshake;
  logic pop;
  logic head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A locked walker keeps the port; otherwise a lone requester wins and a
  // tie goes to the round-robin favourite. With nobody requesting, sel falls
  // to 0 so the forwarded fields are slave 0's.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (s0_mem_req && s1_mem_req) begin
      sel = rr_q;
    end else if (s1_mem_req) begin
      sel = 1'b1;
    end
  end

  assign sel_req       = sel ? s1_mem_req : s0_mem_req;
  assign fifo_full     = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_nonempty = (count_q != '0);

  // The full check uses the registered count, so a pop in the same cycle
  // does not unblock the request until the following cycle.
  assign m_mem_req   = sel_req & ~fifo_full;
  assign m_mem_addr  = sel ? s1_mem_addr  : s0_mem_addr;
  assign m_mem_wdata = sel ? s1_mem_wdata : s0_mem_wdata;
  assign m_mem_we    = sel ? s1_mem_we    : s0_mem_we;
  assign m_mem_be    = sel ? s1_mem_be    : s0_mem_be;

  assign handshake  = m_mem_req & m_mem_gnt;
  assign s0_mem_gnt = handshake & ~sel;
  assign s1_mem_gnt = handshake &  sel;

  // Responses with nothing outstanding are dropped rather than routed.
  assign pop          = m_mem_valid & fifo_nonempty;
  assign head_id      = id_fifo_q[rd_ptr_q];
  assign s0_mem_valid = pop & ~head_id;
  assign s1_mem_valid = pop &  head_id;
  assign s0_mem_rdata = m_mem_rdata;
  assign s1_mem_rdata = m_mem_rdata;
  assign s0_mem_error = m_mem_error;
  assign s1_mem_error = m_mem_error;

  assign busy_o         = fifo_nonempty | s0_mem_req | s1_mem_req;
  assign protocol_err_o = protocol_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      if (handshake) begin
        rr_q   <= ~sel;
        lock_q <= 1'b0;
      end else if (m_mem_req) begin
        // Presented but not accepted: hold the port for this walker.
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      id_fifo_q      <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      if (handshake) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({handshake, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (m_mem_valid && !fifo_nonempty) begin
        protocol_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpt_mem_arbiter.sv
// tb/tb_mpt_mem_arbiter.sv - self-checking bench for mpt_mem_arbiter

module tb_mpt_mem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          s0_mem_req, s1_mem_req;
  logic          s0_mem_gnt, s1_mem_gnt;
  logic [AW-1:0] s0_mem_addr, s1_mem_addr;
  logic [DW-1:0] s0_mem_wdata, s1_mem_wdata;
  logic          s0_mem_we, s1_mem_we;
  logic [BW-1:0] s0_mem_be, s1_mem_be;
  logic          s0_mem_valid, s1_mem_valid;
  logic [DW-1:0] s0_mem_rdata, s1_mem_rdata;
  logic          s0_mem_error, s1_mem_error;
  logic          m_mem_req, m_mem_gnt;
  logic [AW-1:0] m_mem_addr;
  logic [DW-1:0] m_mem_wdata;
  logic          m_mem_we;
  logic [BW-1:0] m_mem_be;
  logic          m_mem_valid;
  logic [DW-1:0] m_mem_rdata;
  logic          m_mem_error;
  logic          busy_o, protocol_err_o;

  always #5 clk_i = ~clk_i;

  mpt_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s0_mem_req(s0_mem_req), .s0_mem_gnt(s0_mem_gnt), .s0_mem_addr(s0_mem_addr),
    .s0_mem_wdata(s0_mem_wdata), .s0_mem_we(s0_mem_we), .s0_mem_be(s0_mem_be),
    .s0_mem_valid(s0_mem_valid), .s0_mem_rdata(s0_mem_rdata), .s0_mem_error(s0_mem_error),
    .s1_mem_req(s1_mem_req), .s1_mem_gnt(s1_mem_gnt), .s1_mem_addr(s1_mem_addr),
    .s1_mem_wdata(s1_mem_wdata), .s1_mem_we(s1_mem_we), .s1_mem_be(s1_mem_be),
    .s1_mem_valid(s1_mem_valid), .s1_mem_rdata(s1_mem_rdata), .s1_mem_error(s1_mem_error),
    .m_mem_req(m_mem_req), .m_mem_gnt(m_mem_gnt), .m_mem_addr(m_mem_addr),
    .m_mem_wdata(m_mem_wdata), .m_mem_we(m_mem_we), .m_mem_be(m_mem_be),
    .m_mem_valid(m_mem_valid), .m_mem_rdata(m_mem_rdata), .m_mem_error(m_mem_error),
    .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Directed cycle vectors applied from reset with s0 at 0x8000_1000 and
  // s1 at 0x8000_2000. e_asel names the walker whose address must appear
  // on the master port.
  typedef struct {
    bit r0, r1, gnt, vld;
    bit e_mreq, e_g0, e_g1, e_v0, e_v1, e_busy, e_asel;
  } vec_t;

  vec_t vecs[18];

  // Reference model: list of issued walker IDs awaiting a response, the
  // walker currently owning the port (-1 when nobody is stuck waiting),
  // which walker wins the next tie, and the sticky error flag.
  int q_ids[$];
  int owner;
  bit pref;
  bit m_perr;
  bit e_sel, e_mreq, e_g0, e_g1, e_v0, e_v1, e_busy;

  task automatic model_reset();
    q_ids.delete();
    owner  = -1;
    pref   = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic model_eval();
    int cnt;
    bit wants;
    cnt = q_ids.size();
    if (owner >= 0)                   e_sel = owner[0];
    else if (s0_mem_req && s1_mem_req) e_sel = pref;
    else                               e_sel = s1_mem_req;
    wants  = e_sel ? s1_mem_req : s0_mem_req;
    e_mreq = wants && (cnt < MAXO);
    e_g0   = e_mreq && m_mem_gnt && !e_sel;
    e_g1   = e_mreq && m_mem_gnt &&  e_sel;
    e_v0   = 1'b0;
    e_v1   = 1'b0;
    if (m_mem_valid && cnt > 0) begin
      e_v0 = (q_ids[0] == 0);
      e_v1 = (q_ids[0] == 1);
    end
    e_busy = (cnt != 0) || s0_mem_req || s1_mem_req;
  endtask

  task automatic model_commit();
    if (m_mem_valid) begin
      if (q_ids.size() > 0) void'(q_ids.pop_front());
      else m_perr = 1'b1;
    end
    if (e_mreq && m_mem_gnt) begin
      q_ids.push_back(int'(e_sel));
      pref  = !e_sel;
      owner = -1;
    end else if (e_mreq) begin
      owner = int'(e_sel);
    end
  endtask

  task automatic clear_inputs();
    s0_mem_req = 0; s1_mem_req = 0; m_mem_gnt = 0; m_mem_valid = 0;
    m_mem_rdata = '0; m_mem_error = 0;
    s0_mem_we = 0; s1_mem_we = 0; s0_mem_be = '0; s1_mem_be = '0;
    s0_mem_wdata = '0; s1_mem_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    clear_inputs();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  bit       pend0, pend1;
  bit       hs;
  logic [AW-1:0] e_addr;

  initial begin
    //           r0 r1 g  v   mreq g0 g1 v0 v1 busy asel
    vecs[0]  = '{0, 0, 0, 0,  0,   0, 0, 0, 0, 0,   0};
    vecs[1]  = '{1, 1, 1, 0,  1,   1, 0, 0, 0, 1,   0};
    vecs[2]  = '{1, 1, 1, 1,  1,   0, 1, 1, 0, 1,   1};
    vecs[3]  = '{1, 1, 1, 1,  1,   1, 0, 0, 1, 1,   0};
    vecs[4]  = '{1, 1, 1, 1,  1,   0, 1, 1, 0, 1,   1};
    vecs[5]  = '{0, 0, 0, 1,  0,   0, 0, 0, 1, 1,   0};
    vecs[6]  = '{1, 1, 0, 0,  1,   0, 0, 0, 0, 1,   0};
    vecs[7]  = '{1, 1, 0, 0,  1,   0, 0, 0, 0, 1,   0};
    vecs[8]  = '{1, 1, 0, 0,  1,   0, 0, 0, 0, 1,   0};
    vecs[9]  = '{1, 1, 1, 0,  1,   1, 0, 0, 0, 1,   0};
    vecs[10] = '{0, 1, 1, 0,  1,   0, 1, 0, 0, 1,   1};
    vecs[11] = '{1, 0, 1, 0,  0,   0, 0, 0, 0, 1,   0};
    vecs[12] = '{1, 0, 1, 1,  0,   0, 0, 1, 0, 1,   0};
    vecs[13] = '{1, 0, 1, 0,  1,   1, 0, 0, 0, 1,   0};
    vecs[14] = '{0, 0, 0, 1,  0,   0, 0, 0, 1, 1,   0};
    vecs[15] = '{0, 1, 1, 1,  1,   0, 1, 1, 0, 1,   1};
    vecs[16] = '{0, 0, 0, 1,  0,   0, 0, 0, 1, 1,   0};
    vecs[17] = '{0, 0, 0, 0,  0,   0, 0, 0, 0, 0,   0};

    rst_ni = 1'b0;
    clear_inputs();
    s0_mem_addr = 64'h8000_1000;
    s1_mem_addr = 64'h8000_2000;
    #2;
    check("reset_gnt0", s0_mem_gnt, 0);
    check("reset_gnt1", s1_mem_gnt, 0);
    check("reset_valid0", s0_mem_valid, 0);
    check("reset_valid1", s1_mem_valid, 0);
    check("reset_m_req", m_mem_req, 0);
    check("reset_busy", busy_o, 0);
    check("reset_perr", protocol_err_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk_i);
      s0_mem_req  = vecs[i].r0;
      s1_mem_req  = vecs[i].r1;
      m_mem_gnt   = vecs[i].gnt;
      m_mem_valid = vecs[i].vld;
      m_mem_rdata = 64'hDEAD_BEEF + 64'(i);
      m_mem_error = i[0];
      #1;
      check($sformatf("vec%0d_m_req", i), m_mem_req, vecs[i].e_mreq);
      check($sformatf("vec%0d_gnt0", i), s0_mem_gnt, vecs[i].e_g0);
      check($sformatf("vec%0d_gnt1", i), s1_mem_gnt, vecs[i].e_g1);
      check($sformatf("vec%0d_valid0", i), s0_mem_valid, vecs[i].e_v0);
      check($sformatf("vec%0d_valid1", i), s1_mem_valid, vecs[i].e_v1);
      check($sformatf("vec%0d_busy", i), busy_o, vecs[i].e_busy);
      check($sformatf("vec%0d_addr", i), m_mem_addr,
            vecs[i].e_asel ? 64'h8000_2000 : 64'h8000_1000);
      check($sformatf("vec%0d_rdata0", i), s0_mem_rdata, 64'hDEAD_BEEF + 64'(i));
      check($sformatf("vec%0d_error1", i), s1_mem_error, i[0]);
      check($sformatf("vec%0d_perr", i), protocol_err_o, 0);
    end

    // Spurious response with nothing outstanding: dropped, sticky error.
    @(negedge clk_i);
    m_mem_valid = 1'b1;
    #1;
    check("spur_valid0", s0_mem_valid, 0);
    check("spur_valid1", s1_mem_valid, 0);
    check("spur_perr_before_edge", protocol_err_o, 0);
    @(negedge clk_i);
    m_mem_valid = 1'b0;
    #1;
    check("spur_perr_set", protocol_err_o, 1);
    repeat (3) @(negedge clk_i);
    #1;
    check("spur_perr_sticky", protocol_err_o, 1);
    rst_ni = 1'b0;
    #1;
    check("spur_perr_cleared_by_reset", protocol_err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset with one transaction outstanding: the late response is spurious.
    @(negedge clk_i);
    s0_mem_req = 1'b1;
    m_mem_gnt  = 1'b1;
    #1;
    check("midrst_gnt0", s0_mem_gnt, 1);
    @(negedge clk_i);
    s0_mem_req = 1'b0;
    m_mem_gnt  = 1'b0;
    #1;
    check("midrst_busy_outstanding", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    check("midrst_busy_after_reset", busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    m_mem_valid = 1'b1;
    #1;
    check("midrst_late_valid0", s0_mem_valid, 0);
    @(negedge clk_i);
    m_mem_valid = 1'b0;
    #1;
    check("midrst_late_perr", protocol_err_o, 1);

    // Randomized traffic against the reference model.
    do_reset();
    pend0 = 0;
    pend1 = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      if (!pend0 && $urandom_range(0, 2) != 0) begin
        pend0 = 1;
        s0_mem_addr  = {$urandom, $urandom};
        s0_mem_wdata = {$urandom, $urandom};
        s0_mem_we    = $urandom_range(0, 1) == 1;
        s0_mem_be    = BW'($urandom);
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1;
        s1_mem_addr  = {$urandom, $urandom};
        s1_mem_wdata = {$urandom, $urandom};
        s1_mem_we    = $urandom_range(0, 1) == 1;
        s1_mem_be    = BW'($urandom);
      end
      s0_mem_req  = pend0;
      s1_mem_req  = pend1;
      m_mem_gnt   = $urandom_range(0, 3) != 0;
      m_mem_valid = (q_ids.size() > 0) && ($urandom_range(0, 1) == 1);
      m_mem_rdata = {$urandom, $urandom};
      m_mem_error = $urandom_range(0, 7) == 0;
      #1;
      model_eval();
      e_addr = e_sel ? s1_mem_addr : s0_mem_addr;
      check("rnd_m_req", m_mem_req, e_mreq);
      check("rnd_gnt0", s0_mem_gnt, e_g0);
      check("rnd_gnt1", s1_mem_gnt, e_g1);
      check("rnd_valid0", s0_mem_valid, e_v0);
      check("rnd_valid1", s1_mem_valid, e_v1);
      check("rnd_busy", busy_o, e_busy);
      check("rnd_perr", protocol_err_o, m_perr);
      check("rnd_addr", m_mem_addr, e_addr);
      check("rnd_wdata", m_mem_wdata, e_sel ? s1_mem_wdata : s0_mem_wdata);
      check("rnd_we", m_mem_we, e_sel ? s1_mem_we : s0_mem_we);
      check("rnd_be", m_mem_be, e_sel ? s1_mem_be : s0_mem_be);
      check("rnd_rdata1", s1_mem_rdata, m_mem_rdata);
      check("rnd_error0", s0_mem_error, m_mem_error);
      @(posedge clk_i);
      hs = e_mreq && m_mem_gnt;
      if (hs && !e_sel) pend0 = 0;
      if (hs &&  e_sel) pend1 = 0;
      model_commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
